// File: rtl/ped_sched_pkg.sv
// Shared types and constants for the pedestrian request scheduler.
// Approach encoding, FSM states and a counter width helper.
package ped_sched_pkg;

  localparam logic DIR_NORTH = 1'b0;
  localparam logic DIR_WEST  = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ped_request_scheduler_conditioner.sv
// Push-button conditioner: multi-flop synchronizer, debouncer with a stable-run
// counter, and a one-cycle pulse on each debounced rising edge.
module ped_button_conditioner
  import ped_sched_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic press_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   state_prev_q, state_prev_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d        = '0;
    state_d      = state_q;
    state_prev_d = state_q;
    // The counter only runs while the synced level disagrees with the accepted state.
    if (synced != state_q) begin
      if (cnt_q == DB_LAST) begin
        state_d = synced;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      state_q      <= 1'b0;
      state_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      state_prev_q <= state_prev_d;
    end
  end

  assign press_o = state_q & ~state_prev_q;

endmodule

// File: rtl/ped_request_scheduler.sv
// Pedestrian extension scheduler: latches conditioned presses, then offers one
// green-extension request at a time, round-robin with per-approach hold-off.
module ped_request_scheduler
  import ped_sched_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic north_ped_in,
  input  logic west_ped_in,
  input  logic north_green,
  input  logic west_green,
  input  logic ext_ack,
  output logic ext_req,
  output logic ext_dir,
  output logic north_pending,
  output logic west_pending,
  output logic conflict_err
);

  localparam int HW = cnt_width(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  logic [1:0]    press, green, elig, clr, load;
  logic [1:0]    pending_q, pending_d;
  logic [HW-1:0] holdoff_q [2];
  logic [HW-1:0] holdoff_d [2];
  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic          rr_last_q, rr_last_d;
  logic          conflict_q, conflict_d;

  ped_button_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_north_btn (
    .clk    (clk),
    .rst    (rst),
    .raw_in (north_ped_in),
    .press_o(press[DIR_NORTH])
  );

  ped_button_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_west_btn (
    .clk    (clk),
    .rst    (rst),
    .raw_in (west_ped_in),
    .press_o(press[DIR_WEST])
  );

  assign green = {west_green, north_green};

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      elig[d] = pending_q[d] & green[d] & (holdoff_q[d] == '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rr_last_d = rr_last_q;
    clr       = '0;
    load      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (elig[DIR_NORTH] && elig[DIR_WEST]) begin
          dir_d   = ~rr_last_q;
          state_d = S_REQ;
        end else if (elig[DIR_NORTH]) begin
          dir_d   = DIR_NORTH;
          state_d = S_REQ;
        end else if (elig[DIR_WEST]) begin
          dir_d   = DIR_WEST;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // An ack wins over a simultaneous green drop.
        if (ext_ack) begin
          clr[dir_q]  = 1'b1;
          load[dir_q] = 1'b1;
          rr_last_d   = dir_q;
          state_d     = S_IDLE;
        end else if (!green[dir_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pending_d  = (pending_q & ~clr) | press;
    conflict_d = conflict_q | (north_green & west_green);
    for (int d = 0; d < 2; d++) begin
      if (load[d]) begin
        holdoff_d[d] = HOLD_LOAD;
      end else if (holdoff_q[d] != '0) begin
        holdoff_d[d] = holdoff_q[d] - HW'(1);
      end else begin
        holdoff_d[d] = holdoff_q[d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dir_q        <= DIR_NORTH;
      rr_last_q    <= DIR_WEST;
      pending_q    <= '0;
      conflict_q   <= 1'b0;
      holdoff_q[0] <= '0;
      holdoff_q[1] <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      rr_last_q    <= rr_last_d;
      pending_q    <= pending_d;
      conflict_q   <= conflict_d;
      holdoff_q[0] <= holdoff_d[0];
      holdoff_q[1] <= holdoff_d[1];
    end
  end

  assign ext_req       = (state_q == S_REQ);
  assign ext_dir       = dir_q;
  assign north_pending = pending_q[DIR_NORTH];
  assign west_pending  = pending_q[DIR_WEST];
  assign conflict_err  = conflict_q;

endmodule

// File: doc/ped_request_scheduler.md
# ped_request_scheduler

Synchronous scheduler that conditions the north and west pedestrian push-buttons and turns presses into green-extension requests for the intersection light controller. It latches each press as a pending request and presents at most one request at a time to the light controller, only while the requesting approach is green. Approach selection is round-robin, and a per-approach hold-off enforces a minimum spacing between grants.

## Interface
- SYNC_STAGES, 2: synchronizer flops per button (≥2).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a level change (≥1, ≤255).
- HOLDOFF_CYCLES, 64: cycles after a grant before the same approach can be granted again (≥1, ≤65535).
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- north_ped_in  in  1  raw north button, asynchronous to clk.
- west_ped_in  in  1  raw west button, asynchronous to clk.
- north_green  in  1  north green phase active, extension window open; synchronous.
- west_green  in  1  west green phase active, extension window open; synchronous.
- ext_ack  in  1  light controller accepted the extension; synchronous, sampled only while ext_req=1.
- ext_req  out  1  extension request.
- ext_dir  out  1  approach of the request: 0 = north, 1 = west. Valid while ext_req=1, otherwise held.
- north_pending  out  1  north request latched and not yet serviced (walk-wait lamp).
- west_pending  out  1  west request latched and not yet serviced.
- conflict_err  out  1  sticky; set when north_green and west_green are both high. Cleared only by rst.

## Operation
- Conditioning, per button:
  - SYNC_STAGES flop synchronizer feeds the debouncer.
  - Debouncer keeps a state bit (reset 0) and a counter that increments while the synced value ≠ state and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, state takes the synced value and the counter clears.
  - A rising edge of state produces a one-cycle press pulse.
- Pending bits:
  - Set on a press pulse.
  - Cleared on an accepted grant for that approach.
  - A press while already pending is absorbed (no queueing, no count).
  - Set and clear in the same cycle for the same approach: set wins.
- Eligibility of approach d: pending[d] & green[d] & (holdoff_cnt[d]==0).
- FSM IDLE:
  - ext_req=0.
  - If one approach is eligible, go to REQ with ext_dir=d.
  - If both are eligible (only possible during a conflict), choose the approach not served last; the round-robin pointer resets to "west served last", so north goes first.
- FSM REQ:
  - ext_req=1 and ext_dir stable.
  - If ext_ack=1: clear pending[ext_dir], load holdoff_cnt[ext_dir]=HOLDOFF_CYCLES, update the pointer, go to IDLE.
  - Else if green[ext_dir]=0: withdraw; go to IDLE with pending kept and the pointer unchanged.
  - ack and green dropping in the same cycle count as an accepted grant.
- Hold-off counters decrement to 0 independently every cycle and saturate at 0.
- conflict_err sets on any cycle where both greens are high. Scheduling continues regardless.

## Timing
- Reset values: ext_req=0, ext_dir=0, both pending=0, conflict_err=0. Also debouncer states 0, hold-off counters 0, FSM IDLE.
- rst asserted mid-request: ext_req drops asynchronously and the pending request is lost.
- Button-to-pending latency: pending is high SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first edge that samples the raw high. This assumes the raw level stays high throughout.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no press.
- ext_req rises one edge after eligibility is first true, since it is registered.
- ext_ack is sampled at the edge. ext_req and the pending bit fall at that same edge, so a single-cycle ack is sufficient.
- An ack held high across a later request is treated as immediate acceptance of that request.
- ext_req is never high for two different ext_dir values without at least one IDLE cycle between them.
- Release of a button requires a debounce as well. A new press is recognised only after a debounced 0→1 transition.

## Structure
- Package ped_sched_pkg holds:
  - DIR_NORTH=1'b0 and DIR_WEST=1'b1.
  - FSM state encoding (S_IDLE, S_REQ).
  - Width helper for the counters.
- Sub-module ped_button_conditioner (synchronizer, debouncer, rising-edge pulse), instantiated twice.
- Hold-off counters, pending bits, round-robin pointer and FSM live at top level.
- Expected RTL size: about 180 lines.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=10.

1. **Single press, north green.** north_ped_in high for 20 cycles with north_green=1 → north_pending=1 at edge 7, ext_req=1 with ext_dir=0 at edge 8. ext_ack at edge 10 → ext_req=0 and north_pending=0 at edge 10.
2. **Glitch rejection.** 3-cycle pulse on west_ped_in → west_pending stays 0. A 20-cycle press then sets west_pending. With west_green=0, ext_req stays 0 until west_green rises, then asserts 1 cycle later.
3. **Hold-off.** Ack a north grant at cycle T, then press north again and keep it high → ext_req for north does not re-assert before T+11.
4. **Withdraw.** While in REQ for west, drop west_green without ack → ext_req=0 next edge and west_pending remains 1. Raising west_green again → ext_req re-asserts.
5. **Conflict and round-robin.** Both pending, both green → conflict_err=1 (sticky). First grant is north, after ack the next is west.
6. **Reset mid-REQ.** Assert rst while ext_req=1 → outputs drop immediately. After release, pending=0 and no request is issued.
